skeleton_sequencer: RTL and testbench

- Control FSM that sequences one on-device skeleton (e.g. the echo/test skeleton) for the FPGA test flow.
- Accepts input words from the host-side transfer logic over a valid/ready stream and drives the skeleton's DATA_IN, EN and TRGG_START_CALC.
- Waits for the skeleton's DATA_VALID, with a timeout, and returns the result word over a second valid/ready stream.
- Latches the skeleton header once so host logic can read the skeleton properties.

---
 rtl/skeleton_pkg.sv | 36 +++
 rtl/skeleton_timeout_cnt.sv | 34 +++
 rtl/skeleton_sequencer.sv | 169 ++++++++++++++++
 tb/tb_skeleton_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/skeleton_pkg.sv
// Shared types and header-field layout for the skeleton sequencer and any
// controller that needs to decode a latched skeleton header.
package skeleton_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TRIG,
    ST_WAIT,
    ST_RESULT,
    ST_FLUSH
  } state_e;

  localparam int HEAD_W = 26;

  // Header layout, LSB first: {id, num_out, num_in, bw_out, bw_in}
  localparam int HEAD_BW_IN_LSB   = 0;
  localparam int HEAD_BW_IN_W     = 5;
  localparam int HEAD_BW_OUT_LSB  = 5;
  localparam int HEAD_BW_OUT_W    = 5;
  localparam int HEAD_NUM_IN_LSB  = 10;
  localparam int HEAD_NUM_IN_W    = 6;
  localparam int HEAD_NUM_OUT_LSB = 16;
  localparam int HEAD_NUM_OUT_W   = 6;
  localparam int HEAD_ID_LSB      = 22;
  localparam int HEAD_ID_W        = 4;

  function automatic logic [HEAD_ID_W-1:0] head_id(input logic [HEAD_W-1:0] head);
    return head[HEAD_ID_LSB +: HEAD_ID_W];
  endfunction

  function automatic logic [HEAD_BW_IN_W-1:0] head_bw_in(input logic [HEAD_W-1:0] head);
    return head[HEAD_BW_IN_LSB +: HEAD_BW_IN_W];
  endfunction

endpackage

// File: rtl/skeleton_timeout_cnt.sv
// Loadable up-counter with clear, enable and a terminal-count flag; shared by
// the trigger hold and the result-wait timeout of the sequencer.
module skeleton_timeout_cnt #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/skeleton_sequencer.sv
// Control FSM that feeds one word at a time to an on-device skeleton, waits
// for its result with a timeout, and returns the result to the host stream.
module skeleton_sequencer
  import skeleton_pkg::*;
#(
  parameter int BITWIDTH_DATA  = 16,
  parameter int BITWIDTH_HEAD  = 26,
  parameter int TRIG_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BITWIDTH_CNT   = 16
) (
  input  logic                     CLK_SYS,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [BITWIDTH_DATA-1:0] IN_DATA,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [BITWIDTH_DATA-1:0] OUT_DATA,
  output logic                     OUT_ERR,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     SKL_EN,
  output logic                     SKL_TRGG_START_CALC,
  output logic [BITWIDTH_DATA-1:0] SKL_DATA_IN,
  input  logic [BITWIDTH_DATA-1:0] SKL_DATA_OUT,
  input  logic [BITWIDTH_HEAD-1:0] SKL_DATA_HEAD,
  input  logic                     SKL_DATA_VALID,
  output logic [BITWIDTH_HEAD-1:0] HEAD_OUT,
  output logic                     BUSY,
  output logic [BITWIDTH_CNT-1:0]  CNT_DONE
);

  // Counter must hold both TRIG_CYCLES-1 (<=14) and TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 16) ? $clog2(TIMEOUT_CYCLES) : 4;
  localparam logic [CNT_W-1:0] TRIG_TERM    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic [BITWIDTH_DATA-1:0] out_data_q, out_data_d;
  logic                     out_err_q, out_err_d;
  logic                     out_valid_q, out_valid_d;
  logic                     skl_en_q, skl_en_d;
  logic                     trig_q, trig_d;
  logic [BITWIDTH_DATA-1:0] skl_data_in_q, skl_data_in_d;
  logic [BITWIDTH_HEAD-1:0] head_out_q, head_out_d;
  logic                     head_vld_q, head_vld_d;
  logic                     busy_q, busy_d;
  logic [BITWIDTH_CNT-1:0]  cnt_done_q, cnt_done_d;

  logic                     cnt_clr;
  logic                     cnt_tc;
  logic [CNT_W-1:0]         cnt_term;

  skeleton_timeout_cnt #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk       (CLK_SYS),
    .rst       (RST),
    .clr_i     (cnt_clr),
    .load_i    (1'b0),
    .load_val_i('0),
    .en_i      (1'b1),
    .term_i    (cnt_term),
    .tc_o      (cnt_tc)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    out_data_d    = out_data_q;
    out_err_d     = out_err_q;
    skl_data_in_d = skl_data_in_q;
    cnt_done_d    = cnt_done_q;
    head_out_d    = head_out_q;
    head_vld_d    = head_vld_q;
    cnt_term      = (state_q == ST_TRIG) ? TRIG_TERM : TIMEOUT_TERM;

    if (!EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!head_vld_q) begin
            head_out_d = SKL_DATA_HEAD;
            head_vld_d = 1'b1;
          end
          if (in_ready_q && IN_VALID) begin
            skl_data_in_d = IN_DATA;
            state_d       = ST_LOAD;
          end
        end
        ST_LOAD: state_d = ST_TRIG;
        ST_TRIG: if (cnt_tc) state_d = ST_WAIT;
        ST_WAIT: begin
          // A result arriving on the timeout cycle still counts as valid.
          if (SKL_DATA_VALID) begin
            out_data_d = SKL_DATA_OUT;
            out_err_d  = 1'b0;
            state_d    = ST_RESULT;
          end else if (cnt_tc) begin
            out_data_d = '0;
            out_err_d  = 1'b1;
            state_d    = ST_FLUSH;
          end
        end
        ST_FLUSH: state_d = ST_RESULT;
        ST_RESULT: begin
          if (OUT_READY) begin
            state_d = ST_IDLE;
            if (!out_err_q) cnt_done_d = cnt_done_q + BITWIDTH_CNT'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    in_ready_d  = (state_d == ST_IDLE) && EN;
    skl_en_d    = EN && (state_d != ST_FLUSH);
    trig_d      = (state_d == ST_TRIG);
    out_valid_d = (state_d == ST_RESULT);
    busy_d      = (state_d != ST_IDLE);
    cnt_clr     = (state_d != state_q);
  end

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b0;
      out_data_q    <= '0;
      out_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      skl_en_q      <= 1'b0;
      trig_q        <= 1'b0;
      skl_data_in_q <= '0;
      head_out_q    <= '0;
      head_vld_q    <= 1'b0;
      busy_q        <= 1'b0;
      cnt_done_q    <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_data_q    <= out_data_d;
      out_err_q     <= out_err_d;
      out_valid_q   <= out_valid_d;
      skl_en_q      <= skl_en_d;
      trig_q        <= trig_d;
      skl_data_in_q <= skl_data_in_d;
      head_out_q    <= head_out_d;
      head_vld_q    <= head_vld_d;
      busy_q        <= busy_d;
      cnt_done_q    <= cnt_done_d;
    end
  end

  assign IN_READY            = in_ready_q;
  assign OUT_DATA            = out_data_q;
  assign OUT_ERR             = out_err_q;
  assign OUT_VALID           = out_valid_q;
  assign SKL_EN              = skl_en_q;
  assign SKL_TRGG_START_CALC = trig_q;
  assign SKL_DATA_IN         = skl_data_in_q;
  assign HEAD_OUT            = head_out_q;
  assign BUSY                = busy_q;
  assign CNT_DONE            = cnt_done_q;

endmodule

// File: tb/tb_skeleton_sequencer.sv
// Self-checking bench: two sequencers (TRIG_CYCLES 1 and 4) with echo skeleton
// stubs; table-driven single words plus hand-written multi-cycle sequences.
module tb_skeleton_sequencer;

  localparam logic [25:0] HEAD = {4'd0, 6'd1, 6'd1, 5'd16, 5'd16};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en, in_valid, out_ready, skl_mute;
  logic [15:0] in_data;
  logic        in_ready, out_err, out_valid, skl_en, skl_trig, busy;
  logic [15:0] out_data, skl_din, cnt_done;
  logic [15:0] skl_dout;
  logic        skl_valid;
  logic [25:0] head_out;

  logic        en4, in_valid4;
  logic        in_ready4, out_err4, out_valid4, skl_en4, skl_trig4, busy4;
  logic [15:0] out_data4, skl_din4, cnt4, skl_dout4;
  logic        skl_valid4;
  logic [25:0] head_out4;

  skeleton_sequencer #(.TRIG_CYCLES(1), .TIMEOUT_CYCLES(8)) u_dut (
    .CLK_SYS(clk), .RST(rst), .EN(en), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .OUT_DATA(out_data), .OUT_ERR(out_err), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .SKL_EN(skl_en), .SKL_TRGG_START_CALC(skl_trig),
    .SKL_DATA_IN(skl_din), .SKL_DATA_OUT(skl_dout), .SKL_DATA_HEAD(HEAD),
    .SKL_DATA_VALID(skl_valid), .HEAD_OUT(head_out), .BUSY(busy), .CNT_DONE(cnt_done)
  );

  skeleton_sequencer #(.TRIG_CYCLES(4), .TIMEOUT_CYCLES(8)) u_dut4 (
    .CLK_SYS(clk), .RST(rst), .EN(en4), .IN_DATA(in_data), .IN_VALID(in_valid4),
    .IN_READY(in_ready4), .OUT_DATA(out_data4), .OUT_ERR(out_err4), .OUT_VALID(out_valid4),
    .OUT_READY(out_ready), .SKL_EN(skl_en4), .SKL_TRGG_START_CALC(skl_trig4),
    .SKL_DATA_IN(skl_din4), .SKL_DATA_OUT(skl_dout4), .SKL_DATA_HEAD(HEAD),
    .SKL_DATA_VALID(skl_valid4), .HEAD_OUT(head_out4), .BUSY(busy4), .CNT_DONE(cnt4)
  );

  // Echo skeleton: result pulses the cycle after a trigger is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skl_valid <= 1'b0;
      skl_dout  <= '0;
    end else if (!skl_en) begin
      skl_valid <= 1'b0;
    end else begin
      skl_valid <= skl_trig && !skl_mute;
      if (skl_trig) skl_dout <= skl_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skl_valid4 <= 1'b0;
      skl_dout4  <= '0;
    end else if (!skl_en4) begin
      skl_valid4 <= 1'b0;
    end else begin
      skl_valid4 <= skl_trig4;
      if (skl_trig4) skl_dout4 <= skl_din4;
    end
  end

  int skl_en_low = 0;
  always @(negedge clk) if (!rst && en && !skl_en) skl_en_low <= skl_en_low + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Latency counts clock edges from the handshake edge (inclusive) to the
  // edge after which OUT_VALID is seen high.
  task automatic send_word(input logic [15:0] d, output int lat);
    int n;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin @(negedge clk); lat++; end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t        vecs[3];
  logic [15:0] b2b[3];

  initial begin
    int lat, n, bad, en_low_start;

    vecs[0] = '{din: 16'hA5C3, exp_dout: 16'hA5C3, exp_cnt: 16'd1};
    vecs[1] = '{din: 16'h0000, exp_dout: 16'h0000, exp_cnt: 16'd2};
    vecs[2] = '{din: 16'h5A5A, exp_dout: 16'h5A5A, exp_cnt: 16'd3};
    b2b[0] = 16'h0001;
    b2b[1] = 16'hFFFF;
    b2b[2] = 16'h8000;

    en = 1'b0; in_valid = 1'b0; out_ready = 1'b1; skl_mute = 1'b0;
    in_data = '0; en4 = 1'b0; in_valid4 = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_outs", {in_ready, out_err, out_valid, skl_en, skl_trig, busy},  32'd0);
    check("rst_data", {out_data, skl_din}, 32'd0);
    check("rst_head_cnt", {head_out, cnt_done[5:0]}, 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("head_latched", 32'(head_out), 32'(HEAD));
    check("idle_ready", {in_ready, skl_en, busy}, 32'b110);

    // Single words through the echo skeleton
    for (int i = 0; i < 3; i++) begin
      send_word(vecs[i].din, lat);
      check("latency", 32'(lat), 32'd4);
      check("echo_data", 32'(out_data), 32'(vecs[i].exp_dout));
      check("echo_err", 32'(out_err), 32'd0);
      @(negedge clk);
      check("valid_drop", 32'(out_valid), 32'd0);
      check("cnt_done", 32'(cnt_done), 32'(vecs[i].exp_cnt));
    end

    // Back-to-back words with IN_VALID held high
    @(negedge clk);
    in_data  = b2b[0];
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check("b2b_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("b2b_ready_low", 32'(in_ready), 32'd0);
      if (k < 2) in_data = b2b[k+1];
      else in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      check("b2b_data", 32'(out_data), 32'(b2b[k]));
    end
    @(negedge clk);
    check("b2b_cnt", 32'(cnt_done), 32'd6);

    // Backpressure: result must hold while OUT_READY is low
    out_ready = 1'b0;
    send_word(16'h3C3C, lat);
    check("bp_latency", 32'(lat), 32'd4);
    in_data  = 16'hBEEF;
    in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!out_valid || out_data !== 16'h3C3C || in_ready) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_no_accept", 32'(skl_din), 32'h3C3C);
    check("bp_cnt_hold", 32'(cnt_done), 32'd6);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {out_valid, cnt_done}, {1'b0, 16'd7});
    @(negedge clk);
    @(negedge clk);
    check("bp_idle", 32'(busy), 32'd0);

    // Timeout: skeleton never answers
    skl_mute = 1'b1;
    @(negedge clk);
    en_low_start = skl_en_low;
    send_word(16'h7777, lat);
    check("to_latency", 32'(lat), 32'd12);
    check("to_err", 32'(out_err), 32'd1);
    check("to_data", 32'(out_data), 32'd0);
    check("to_flush_cycles", 32'(skl_en_low - en_low_start), 32'd1);
    @(negedge clk);
    check("to_cnt_hold", {out_valid, cnt_done}, {1'b0, 16'd7});
    skl_mute = 1'b0;

    // EN drop during TRIG on the TRIG_CYCLES=4 instance
    en4 = 1'b1;
    @(negedge clk);
    in_data   = 16'h5555;
    in_valid4 = 1'b1;
    n = 0;
    while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
    check("e4_ready", 32'(in_ready4), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    check("e4_trig", 32'(skl_trig4), 32'd1);
    @(negedge clk);
    en4 = 1'b0;
    @(negedge clk);
    check("e4_abort", {busy4, skl_trig4, skl_en4, out_valid4}, 32'd0);
    check("e4_keep", {head_out4, cnt4[5:0]}, {HEAD, 6'd0});
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid4) bad++;
    end
    check("e4_no_result", 32'(bad), 32'd0);
    en4 = 1'b1;
    @(negedge clk);
    in_data   = 16'h1234;
    in_valid4 = 1'b1;
    n = 0;
    while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 60) begin @(negedge clk); lat++; end
    check("e4_latency", 32'(lat), 32'd7);
    check("e4_data", {out_err4, out_data4}, {1'b0, 16'h1234});
    @(negedge clk);
    check("e4_cnt", 32'(cnt4), 32'd1);

    // Asynchronous reset in the middle of WAIT
    skl_mute = 1'b1;
    @(negedge clk);
    in_data  = 16'h9999;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ar_busy", {busy, skl_en, out_valid}, 32'b110);
    #2 rst = 1'b1;
    #1;
    check("ar_outs", {in_ready, out_err, out_valid, skl_en, skl_trig, busy}, 32'd0);
    check("ar_data", {out_data, skl_din}, 32'd0);
    check("ar_cnt", 32'(cnt_done), 32'd0);
    check("ar_head", 32'(head_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
